// File: rtl/sseg_mux_driver.sv
// sseg_mux_driver: time-multiplexed common-anode seven-segment driver with per-frame input buffering.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en                scan enable; low holds the scan and turns every anode off
//   digits_i          packed 4-bit codes, digit k at [4k+3:4k], digit 0 rightmost
//   dp_i, blank_i     per-digit decimal point request / blank request (1 = lit / dark)
//   sseg_o, dp_o      active-low segments {a,b,c,d,e,f,g} and decimal point, registered
//   an_o              active-low anode enables, registered
// Define SSEG_HEX_EN to display codes 10..15 as A b C d E F; otherwise they are dark.
module sseg_mux_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  output logic [6:0]              sseg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o
);
  localparam int DW = $clog2(REFRESH_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [DW-1:0]           div_cnt, nxt_div;
  logic [IW-1:0]           idx, nxt_idx;
  logic                    started, wrap, start, dark;
  logic [4*NUM_DIGITS-1:0] fb_dig, nxt_dig;
  logic [NUM_DIGITS-1:0]   fb_dp, nxt_dp, fb_blank, nxt_blank, an_nxt;
  logic [3:0]              code;
  function automatic logic [6:0] seg_of(input logic [3:0] c);
    case (c)
      4'd0:    seg_of = 7'b0000001;
      4'd1:    seg_of = 7'b1001111;
      4'd2:    seg_of = 7'b0010010;
      4'd3:    seg_of = 7'b0000110;
      4'd4:    seg_of = 7'b1001100;
      4'd5:    seg_of = 7'b0100100;
      4'd6:    seg_of = 7'b0100000;
      4'd7:    seg_of = 7'b0001111;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0000100;
`ifdef SSEG_HEX_EN
      4'd10:   seg_of = 7'b0001000;
      4'd11:   seg_of = 7'b1100000;
      4'd12:   seg_of = 7'b0110001;
      4'd13:   seg_of = 7'b1000010;
      4'd14:   seg_of = 7'b0110000;
      4'd15:   seg_of = 7'b0111000;
`endif
      default: seg_of = 7'b1111111;
    endcase
  endfunction
  // Outputs are registered from the next-state values, so the cycle after a
  // frame start edge already shows slot 0, cycle 0 with the freshly captured inputs.
  always_comb begin
    wrap      = div_cnt == DW'(REFRESH_DIV - 1);
    start     = !started || (wrap && idx == IW'(NUM_DIGITS - 1));
    nxt_div   = (start || wrap) ? '0 : div_cnt + 1'b1;
    nxt_idx   = start ? '0 : wrap ? idx + 1'b1 : idx;
    nxt_dig   = start ? digits_i : fb_dig;
    nxt_dp    = start ? dp_i : fb_dp;
    nxt_blank = start ? blank_i : fb_blank;
    code      = nxt_dig[{nxt_idx, 2'b00} +: 4];
    dark      = nxt_blank[nxt_idx];
    an_nxt    = (nxt_div < DW'(GUARD_CYC)) ? '1 : ~(NUM_DIGITS'(1) << nxt_idx);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started  <= 1'b0;
      div_cnt  <= '0;
      idx      <= '0;
      fb_dig   <= '0;
      fb_dp    <= '0;
      fb_blank <= '1;
      sseg_o   <= 7'b1111111;
      dp_o     <= 1'b1;
      an_o     <= '1;
    end else if (en) begin
      started  <= 1'b1;
      div_cnt  <= nxt_div;
      idx      <= nxt_idx;
      fb_dig   <= nxt_dig;
      fb_dp    <= nxt_dp;
      fb_blank <= nxt_blank;
      sseg_o   <= dark ? 7'b1111111 : seg_of(code);
      dp_o     <= dark | ~nxt_dp[nxt_idx];
      an_o     <= an_nxt;
    end else begin
      an_o     <= '1;
    end
  end
endmodule

// File: tb/tb_sseg_mux_driver.sv
// tb_sseg_mux_driver: directed self-checking bench for sseg_mux_driver (4 digits, 8-cycle slots, 2 guard cycles).
module tb_sseg_mux_driver;
  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b1;
  logic [15:0] digits = 16'h4321;
  logic [3:0]  dp = 4'h0, blank = 4'h0;
  logic [6:0]  sseg;
  logic        dpo;
  logic [3:0]  an;
  int          checks = 0, failures = 0, pos = 31;
  logic [15:0] m_dig = 16'h0;
  logic [3:0]  m_dp = 4'h0, m_blank = 4'hf;
  always #5 clk = ~clk;
  sseg_mux_driver #(.NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .digits_i(digits), .dp_i(dp), .blank_i(blank),
    .sseg_o(sseg), .dp_o(dpo), .an_o(an)
  );
  function automatic logic [6:0] seg_of(input logic [3:0] c);
    logic [6:0] t [16];
    t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
          7'b0000000, 7'b0000100,
`ifdef SSEG_HEX_EN
          7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
`else
          7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f};
`endif
    return t[c];
  endfunction
  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s pos=%0d got{an,sseg,dp}=%b expected=%b", tag, pos, got, exp);
    end
  endtask
  // One clock: the frame position advances only on enabled edges; a new frame latches the inputs.
  task automatic tick(input string tag);
    logic e;
    int k, s;
    logic [6:0] se;
    logic de;
    logic [3:0] ae;
    e = en;
    if (e) begin
      pos = (pos + 1) % 32;
      if (pos == 0) begin
        m_dig = digits;
        m_dp = dp;
        m_blank = blank;
      end
    end
    @(negedge clk);
    k = pos / 8;
    s = pos % 8;
    se = m_blank[k] ? 7'h7f : seg_of(m_dig[4*k +: 4]);
    de = m_blank[k] | ~m_dp[k];
    ae = (!e || s < 2) ? 4'hf : ~(4'b0001 << k);
    chk(tag, {an, sseg, dpo}, {ae, se, de});
  endtask
  initial begin
    @(negedge clk);
    chk("reset_hold", {an, sseg, dpo}, {4'hf, 7'h7f, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (64) tick("scan");
    repeat (18) tick("buf_old");
    digits = 16'h9999;
    repeat (14) tick("buf_old_tail");
    repeat (32) tick("buf_new");
    blank = 4'b1000;
    dp = 4'b1001;
    repeat (32) tick("blank_dp");
    blank = 4'b0000;
    dp = 4'b0000;
    digits = 16'h4321;
    repeat (10) tick("en_pre");
    en = 1'b0;
    repeat (20) tick("en_off");
    en = 1'b1;
    repeat (22) tick("en_resume");
    digits = 16'hFEDA;
    repeat (32) tick("hex");
    digits = 16'h4321;
    repeat (11) tick("pre_reset");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("reset_async", {an, sseg, dpo}, {4'hf, 7'h7f, 1'b1});
    @(negedge clk);
    chk("reset_still", {an, sseg, dpo}, {4'hf, 7'h7f, 1'b1});
    rst_n = 1'b1;
    pos = 31;
    repeat (32) tick("restart");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sseg_mux_driver.md
# sseg_mux_driver

Time-multiplexed driver for a bank of common-anode seven-segment digits. It decodes NUM_DIGITS packed 4-bit codes and scans them one digit at a time onto a shared segment bus with per-digit anode enables. Input values are buffered once per frame so the display never tears mid-scan. It sits between the BCD/counter datapath and the board's display pins, and supersedes the single-digit decoder.

## Interface
Parameters:
- NUM_DIGITS, 4: number of digits scanned; legal range 1..8.
- REFRESH_DIV, 100000: clock cycles per digit slot; must be at least 2.
- GUARD_CYC, 2: cycles at the start of each slot with all anodes off, for ghosting suppression; must be less than REFRESH_DIV.

Ports:
- clk, input, 1: single clock; all state is on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- en, input, 1: scan enable.
- digits_i, input, 4*NUM_DIGITS: packed codes; digit k is bits [4k+3:4k], and digit 0 is the rightmost.
- dp_i, input, NUM_DIGITS: decimal point request per digit; 1 means lit.
- blank_i, input, NUM_DIGITS: per-digit blank; 1 forces the digit dark.
- sseg_o, output, 7: segments {a,b,c,d,e,f,g}; active-low; registered.
- dp_o, output, 1: decimal point; active-low; registered.
- an_o, output, NUM_DIGITS: anode enables; active-low; registered.

## Operation
- Reset (asynchronous, on rst_n low):
  - div_cnt = 0, idx = 0, frame buffer cleared with all digits blanked.
  - sseg_o = 7'b1111111, dp_o = 1, an_o = all ones.
- Counters:
  - div_cnt is $clog2(REFRESH_DIV) bits wide. idx is max(1, $clog2(NUM_DIGITS)) bits wide.
  - div_cnt counts 0..REFRESH_DIV-1 and then wraps.
  - On each div_cnt wrap, idx advances; it wraps from NUM_DIGITS-1 to 0.
- Frame start event:
  - Occurs on the first enabled edge after reset release, and at each div_cnt wrap while idx == NUM_DIGITS-1.
  - On that edge, the frame buffer loads digits_i, dp_i and blank_i, and idx is set to 0.
  - Input changes between frame starts have no effect on the display.
- Decode of buffered code c for the current digit:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - Codes 10..15 follow the Configuration section.
- Blanked digits: sseg_o = 1111111 and dp_o = 1, whatever the code or dp value.
- en = 0:
  - div_cnt, idx and the buffer hold.
  - an_o is forced to all ones on the next edge; sseg_o and dp_o hold.
  - When en is reasserted, the scan resumes from the held div_cnt and idx.
- Outputs are fully registered, with no combinational path from inputs to outputs.

## Timing
- Slot k spans REFRESH_DIV consecutive cycles, with slot cycle s = 0..REFRESH_DIV-1:
  - s < GUARD_CYC: an_o = all ones.
  - s ≥ GUARD_CYC: an_o has only bit k low.
  - sseg_o and dp_o show digit k for the whole slot.
- Output latency: registered outputs lag the internal state by one cycle. Slot 0 cycle 0 is the cycle after the frame start edge.
- Frame period: NUM_DIGITS × REFRESH_DIV cycles. Anode duty per digit is (REFRESH_DIV − GUARD_CYC) / (NUM_DIGITS × REFRESH_DIV).
- Input sampled on the same edge as a frame start: the new value is captured and displayed from slot 0 of that frame.
- rst_n asserted mid-slot: outputs go to their reset values immediately, without waiting for a clock edge. The first edge after release is a frame start.
- NUM_DIGITS = 1: idx stays 0 and every div_cnt wrap is a frame start.

## Configuration
- SSEG_HEX_EN defined:
  - Codes 10..15 display A = 0001000, b = 1100000, C = 0110001, d = 1000010, E = 0110000, F = 0111000.
- SSEG_HEX_EN undefined:
  - Codes 10..15 display 1111111 (dark segments). The dp still follows dp_i.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYC=2.
- Reset:
  - Stimulus: assert rst_n low mid-slot.
  - Required: without any clock edge, an_o = 1111, sseg_o = 1111111, dp_o = 1.
  - Required after release: the first anode low is an_o = 1110, in the third cycle after the frame start edge.
- Scan:
  - Stimulus: digits_i = 16'h4321, dp_i = 0, blank_i = 0, en = 1.
  - Required: an_o cycles through 1110, 1101, 1011, 0111, each low for 6 of every 8 cycles.
  - Required: sseg_o is 1001111, 0010010, 0000110, 1001100 respectively. The frame period is 32 cycles.
- Frame buffering:
  - Stimulus: change digits_i to 16'h9999 during slot 2.
  - Required: slots 2 and 3 still show 3 and 4. The next frame shows 0000100 on all digits.
- Blank and dp:
  - Stimulus: blank_i = 4'b1000, dp_i = 4'b1001.
  - Required: digit 3 shows sseg_o = 1111111 with dp_o = 1. Digit 0 shows dp_o = 0.
- Enable:
  - Stimulus: drop en for 20 cycles during slot 1.
  - Required: an_o = 1111 throughout. The scan resumes in slot 1 at the held div_cnt, and the frame length is extended by exactly 20 cycles.
- Hex:
  - Stimulus: digits_i = 16'hFEDA.
  - Required with SSEG_HEX_EN: 0001000, 1000010, 0110000, 0111000 for digits 0..3.
  - Required without SSEG_HEX_EN: 1111111 for all four digits.
